// File: rtl/wb_stream_burst_ctrl.sv
// ---------------------------------------------------------------------------
// wb_stream_burst_ctrl
//
// Drains a first-word-fall-through FIFO into a circular buffer in Wishbone
// address space using incrementing bursts. A burst starts when the FIFO
// holds at least burst_size words, or when a partial fill has waited for
// `timeout` cycles. Bursts never cross the end of the buffer. When the write
// index wraps back to zero, done_o pulses. In one-shot mode
// (continuous = 0) the engine then parks until enable is dropped.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbm_*                Wishbone B4 master, write-only, registered bus
//                        control; wbm_dat_o is the FIFO head word
//   fifo_d/dv/cnt/rd     FWFT FIFO read side; fifo_rd pops the head word
//   enable               allows new bursts to start
//   start_adr, buf_size  buffer base (byte address) and length (words)
//   burst_size           preferred beats per burst (1..MAX_BURST_LEN)
//   timeout              idle cycles before a partial burst is flushed,
//                        0 disables flushing
//   continuous           1: keep wrapping around the buffer, 0: stop at end
//   busy                 a burst is in progress
//   done_o, err_o        one-cycle pulses: buffer wrapped / bus error
//   cur_idx              word index the next beat will write
// ---------------------------------------------------------------------------
module wb_stream_burst_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 16,
    parameter int TIMEOUT_W     = 8
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,

    // Wishbone master
    output logic [WB_AW-1:0]                   wbm_adr_o,
    output logic [WB_DW-1:0]                   wbm_dat_o,
    output logic [WB_DW/8-1:0]                 wbm_sel_o,
    output logic                               wbm_we_o,
    output logic                               wbm_cyc_o,
    output logic                               wbm_stb_o,
    output logic [2:0]                         wbm_cti_o,
    output logic [1:0]                         wbm_bte_o,
    input  logic [WB_DW-1:0]                   wbm_dat_i,
    input  logic                               wbm_ack_i,
    input  logic                               wbm_err_i,
    input  logic                               wbm_rty_i,

    // FWFT FIFO
    input  logic [WB_DW-1:0]                   fifo_d,
    input  logic                               fifo_dv,
    input  logic [FIFO_AW:0]                   fifo_cnt,
    output logic                               fifo_rd,

    // Configuration
    input  logic                               enable,
    input  logic [WB_AW-1:0]                   start_adr,
    input  logic [WB_AW-1:0]                   buf_size,
    input  logic [$clog2(MAX_BURST_LEN):0]     burst_size,
    input  logic [TIMEOUT_W-1:0]               timeout,
    input  logic                               continuous,

    // Status
    output logic                               busy,
    output logic                               done_o,
    output logic                               err_o,
    output logic [WB_AW-1:0]                   cur_idx
);

    localparam int SEL_W = WB_DW / 8;
    localparam int BW    = $clog2(MAX_BURST_LEN) + 1;   // burst length width
    localparam int CW    = FIFO_AW + 1;                 // fifo count width

    // Common width for comparing lengths coming from differently sized inputs
    localparam int MW0 = (WB_AW > BW) ? WB_AW : BW;
    localparam int MW  = (MW0 > CW) ? MW0 : CW;

    localparam logic [WB_AW-1:0] STRIDE = WB_AW'(SEL_W);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Parameter sanity checks at elaboration
    generate
        if (FIFO_AW < 1) begin : g_bad_fifo_aw
            $error("wb_stream_burst_ctrl: FIFO_AW must be greater than 0");
        end
        if (MAX_BURST_LEN < 1) begin : g_bad_max_burst
            $error("wb_stream_burst_ctrl: MAX_BURST_LEN must be at least 1");
        end
        if ((WB_DW % 8) != 0) begin : g_bad_dw
            $error("wb_stream_burst_ctrl: WB_DW must be a multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               state_reg;
    logic [WB_AW-1:0]     idx_reg;
    logic [BW-1:0]        beat_reg;
    logic [BW-1:0]        len_reg;
    logic [TIMEOUT_W-1:0] tmo_reg;
    logic                 cyc_reg;
    logic                 stb_reg;
    logic                 we_reg;
    logic [2:0]           cti_reg;
    logic [SEL_W-1:0]     sel_reg;
    logic                 done_reg;
    logic                 err_reg;

    // ------------------------------------------------------------------
    // Burst start decision (evaluated while idle)
    // ------------------------------------------------------------------
    logic [WB_AW-1:0] words_left;
    logic [MW-1:0]    bsz_m;
    logic [MW-1:0]    cnt_m;
    logic [MW-1:0]    left_m;
    logic [MW-1:0]    len_cap_m;
    logic [MW-1:0]    len_m;
    logic [BW-1:0]    len_next;
    logic             fill_ok;
    logic             tmo_cond;
    logic             tmo_fire;
    logic             start_burst;

    // An index at or past the buffer end (buf_size shrunk underneath us)
    // yields zero words left, which blocks the start instead of issuing
    // a zero-length burst.
    assign words_left = (idx_reg < buf_size) ? (buf_size - idx_reg) : '0;

    assign bsz_m  = MW'(burst_size);
    assign cnt_m  = MW'(fifo_cnt);
    assign left_m = MW'(words_left);

    assign fill_ok  = (cnt_m >= bsz_m);
    // Flush timer only runs while a partial burst is waiting
    assign tmo_cond = enable && (timeout != '0) && (fifo_cnt != '0) && !fill_ok;
    assign tmo_fire = tmo_cond && (tmo_reg == timeout);

    // Clip to the buffer end, and to the FIFO level on a timeout flush
    assign len_cap_m = (left_m < bsz_m) ? left_m : bsz_m;
    assign len_m     = (tmo_fire && (cnt_m < len_cap_m)) ? cnt_m : len_cap_m;
    assign len_next  = BW'(len_m);

    assign start_burst = (state_reg == S_IDLE) && enable
                         && (fill_ok || tmo_fire) && (len_m != '0);

    // ------------------------------------------------------------------
    // Beat bookkeeping (evaluated while bursting)
    // ------------------------------------------------------------------
    logic             idx_wrap;
    logic [WB_AW-1:0] idx_inc;
    logic             last_beat;
    logic             next_is_last;

    assign idx_wrap     = (idx_reg == (buf_size - WB_AW'(1)));
    assign idx_inc      = idx_wrap ? '0 : (idx_reg + WB_AW'(1));
    assign last_beat    = (beat_reg == (len_reg - BW'(1)));
    // Beat after the one being acked is the final one
    assign next_is_last = ((beat_reg + BW'(2)) == len_reg);

    // ------------------------------------------------------------------
    // Control FSM with registered bus outputs
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            beat_reg  <= '0;
            len_reg   <= '0;
            tmo_reg   <= '0;
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            cti_reg   <= CTI_CLASSIC;
            sel_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (start_burst) begin
                        state_reg <= S_BURST;
                        len_reg   <= len_next;
                        beat_reg  <= '0;
                        tmo_reg   <= '0;
                        cyc_reg   <= 1'b1;
                        stb_reg   <= 1'b1;
                        we_reg    <= 1'b1;
                        sel_reg   <= '1;
                        cti_reg   <= (len_next == BW'(1)) ? CTI_END : CTI_INCR;
                    end else if (tmo_cond) begin
                        tmo_reg <= tmo_reg + TIMEOUT_W'(1);
                    end else begin
                        tmo_reg <= '0;
                    end
                end

                S_BURST: begin
                    tmo_reg <= '0;
                    // ack beats err beats rty
                    if (wbm_ack_i) begin
                        idx_reg  <= idx_inc;
                        beat_reg <= beat_reg + BW'(1);
                        if (idx_wrap) begin
                            done_reg <= 1'b1;
                        end
                        if (last_beat) begin
                            cyc_reg   <= 1'b0;
                            stb_reg   <= 1'b0;
                            we_reg    <= 1'b0;
                            sel_reg   <= '0;
                            cti_reg   <= CTI_CLASSIC;
                            state_reg <= (idx_wrap && !continuous) ? S_HOLD : S_IDLE;
                        end else begin
                            cti_reg <= next_is_last ? CTI_END : CTI_INCR;
                        end
                    end else if (wbm_err_i) begin
                        // Abort; the failed beat stays in the FIFO and
                        // idx still points at it.
                        cyc_reg   <= 1'b0;
                        stb_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        sel_reg   <= '0;
                        cti_reg   <= CTI_CLASSIC;
                        err_reg   <= 1'b1;
                        state_reg <= S_IDLE;
                    end else if (wbm_rty_i) begin
                        // Back off quietly; the idle logic re-evaluates
                        // the burst from the current index and fill.
                        cyc_reg   <= 1'b0;
                        stb_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        sel_reg   <= '0;
                        cti_reg   <= CTI_CLASSIC;
                        state_reg <= S_IDLE;
                    end
                end

                S_HOLD: begin
                    // Buffer filled in one-shot mode: wait for software to
                    // drop enable before arming again.
                    tmo_reg <= '0;
                    if (!enable) begin
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wbm_adr_o = start_adr + (idx_reg * STRIDE);
    assign wbm_dat_o = fifo_d;
    assign wbm_sel_o = sel_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_cyc_o = cyc_reg;
    assign wbm_stb_o = stb_reg;
    assign wbm_cti_o = cti_reg;
    assign wbm_bte_o = 2'b00;

    // Pop exactly the word that the slave accepted
    assign fifo_rd = wbm_ack_i & stb_reg;

    assign busy    = (state_reg == S_BURST);
    assign done_o  = done_reg;
    assign err_o   = err_reg;
    assign cur_idx = idx_reg;

    // Write-only master: read data is ignored, and the FIFO level already
    // tells us whether the head word is valid.
    logic unused_inputs;
    assign unused_inputs = ^{wbm_dat_i, fifo_dv};

endmodule

// File: tb/tb_wb_stream_burst_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for wb_stream_burst_ctrl.
// A queue-based FWFT FIFO feeds the DUT, a Wishbone slave model answers with
// ack (optionally random wait states), err or rty, and a negedge monitor
// compares every beat against a scoreboard of pushed words and an
// independently tracked buffer index. Table-driven scenarios are followed by
// hand-written corner-case sequences.
// ---------------------------------------------------------------------------
module tb_wb_stream_burst_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int FAW = 4;
    localparam int MBL = 16;
    localparam int TW  = 8;
    localparam int BW  = $clog2(MBL) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [AW-1:0]   wbm_adr;
    logic [DW-1:0]   wbm_dat;
    logic [DW/8-1:0] wbm_sel;
    logic            wbm_we, wbm_cyc, wbm_stb;
    logic [2:0]      wbm_cti;
    logic [1:0]      wbm_bte;
    logic [DW-1:0]   wbm_dat_in = '0;
    logic            ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [DW-1:0]   fifo_d = '0;
    logic            fifo_dv = 1'b0;
    logic [FAW:0]    fifo_cnt = '0;
    logic            fifo_rd;
    logic            enable = 1'b0;
    logic [AW-1:0]   start_adr = 32'h1000;
    logic [AW-1:0]   buf_size = 32'd16;
    logic [BW-1:0]   burst_size = BW'(4);
    logic [TW-1:0]   timeout = '0;
    logic            continuous = 1'b1;
    logic            busy, done_o, err_o;
    logic [AW-1:0]   cur_idx;

    wb_stream_burst_ctrl #(
        .WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW), .MAX_BURST_LEN(MBL), .TIMEOUT_W(TW)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat), .wbm_sel_o(wbm_sel),
        .wbm_we_o(wbm_we), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
        .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte), .wbm_dat_i(wbm_dat_in),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
        .fifo_d(fifo_d), .fifo_dv(fifo_dv), .fifo_cnt(fifo_cnt), .fifo_rd(fifo_rd),
        .enable(enable), .start_adr(start_adr), .buf_size(buf_size),
        .burst_size(burst_size), .timeout(timeout), .continuous(continuous),
        .busy(busy), .done_o(done_o), .err_o(err_o), .cur_idx(cur_idx)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model + scoreboard ----------------
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    task automatic fifo_refresh();
        fifo_cnt = (FAW+1)'(fq.size());
        fifo_dv  = (fq.size() != 0);
        fifo_d   = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push_words(input int n);
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            fq.push_back(w);
            exp_q.push_back(w);
        end
        fifo_refresh();
    endtask

    // ---------------- slave model controls ----------------
    bit wait_mode = 0, ack_hold = 0, err_arm = 0, rty_arm = 0;
    int err_after = 0, acks_given = 0;
    bit rd_pending = 0;

    // ---------------- monitor state ----------------
    int cfg_bsz = 4, cfg_buf = 16;
    int m_idx = 0, m_len = 0, m_pos = 0;
    bit prev_cyc = 0, end_expected = 0, exp_done = 0, exp_err = 0;
    int beats = 0, bursts = 0, done_cnt = 0, err_cnt = 0, rty_cnt = 0, errp_cnt = 0;

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Slave + FIFO pop, just after each rising edge
    initial begin
        logic [DW-1:0] dropped;
        forever begin
            @(posedge clk);
            #1;
            if (rd_pending) begin
                if (fq.size() != 0) dropped = fq.pop_front();
                rd_pending = 0;
                fifo_refresh();
            end
            ack = 1'b0; err = 1'b0; rty = 1'b0;
            if (wbm_cyc && wbm_stb && !rst) begin
                if (err_arm && acks_given == err_after) begin
                    err = 1'b1; err_arm = 0;
                end else if (rty_arm) begin
                    rty = 1'b1; rty_arm = 0;
                end else if (!ack_hold && (!wait_mode || $urandom_range(0, 1) == 1)) begin
                    ack = 1'b1; acks_given++;
                end
            end
        end
    end

    // Bus monitor, mid-cycle
    initial begin
        logic [DW-1:0] exp_w;
        logic [AW-1:0] exp_a;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cyc = 0; m_idx = 0; end_expected = 0;
                exp_done = 0; exp_err = 0; rd_pending = 0;
            end else begin
                check("done_o", done_o, exp_done);
                check("err_o", err_o, exp_err);
                exp_done = 0; exp_err = 0;
                if (end_expected) check("cyc_drop", wbm_cyc, 0);
                end_expected = 0;
                check("cur_idx", cur_idx, m_idx);
                check("busy", busy, wbm_cyc);
                check("fifo_rd", fifo_rd, ack & wbm_stb);
                if (wbm_cyc && !prev_cyc) begin
                    m_len = min3(cfg_bsz, cfg_buf - m_idx, int'(fifo_cnt));
                    m_pos = 0;
                    check("burst_start_len_ok", (m_len > 0), 1);
                end
                if (wbm_cyc && wbm_stb) begin
                    exp_a = start_adr + AW'(m_idx) * 4;
                    check("adr", wbm_adr, exp_a);
                    check("we", wbm_we, 1);
                    check("sel", wbm_sel, 4'hF);
                    check("bte", wbm_bte, 0);
                    check("cti", wbm_cti, (m_pos == m_len - 1) ? 3'b111 : 3'b010);
                    if (ack) begin
                        if (exp_q.size() == 0) begin
                            check("scoreboard_nonempty", 0, 1);
                        end else begin
                            exp_w = exp_q.pop_front();
                            check("data", wbm_dat, exp_w);
                        end
                        beats++; m_pos++;
                        if (m_idx == cfg_buf - 1) begin
                            m_idx = 0; exp_done = 1;
                        end else begin
                            m_idx++;
                        end
                        if (m_pos == m_len) begin
                            bursts++; end_expected = 1;
                        end
                    end else if (err) begin
                        exp_err = 1; end_expected = 1; err_cnt++;
                    end else if (rty) begin
                        end_expected = 1; rty_cnt++;
                    end
                end
                if (done_o) done_cnt++;
                if (err_o)  errp_cnt++;
                rd_pending = fifo_rd;
                prev_cyc = wbm_cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        beats = 0; bursts = 0; done_cnt = 0; err_cnt = 0; rty_cnt = 0; errp_cnt = 0;
    endtask

    task automatic set_cfg(input int bsz, input int bsize, input int tmo, input bit cont,
                           input logic [AW-1:0] sadr);
        cfg_bsz = bsz; cfg_buf = bsize;
        burst_size = BW'(bsz); buf_size = AW'(bsize);
        timeout = TW'(tmo); continuous = cont; start_adr = sadr;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0;
        ack_hold = 0; err_arm = 0; rty_arm = 0; wait_mode = 0; acks_given = 0;
        fq.delete(); exp_q.delete(); fifo_refresh();
        repeat (2) tick();
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic run_until_quiet(input string tag);
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 40; i++) begin
            tick();
            if (wbm_cyc) quiet = 0; else quiet++;
        end
        check({tag, " settle"}, (quiet >= 40), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cyc"}, wbm_cyc, 0);
        check({tag, " stb"}, wbm_stb, 0);
        check({tag, " we"}, wbm_we, 0);
        check({tag, " cti"}, wbm_cti, 0);
        check({tag, " bte"}, wbm_bte, 0);
        check({tag, " sel"}, wbm_sel, 0);
        check({tag, " adr"}, wbm_adr, start_adr);
        check({tag, " fifo_rd"}, fifo_rd, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done_o"}, done_o, 0);
        check({tag, " err_o"}, err_o, 0);
        check({tag, " cur_idx"}, cur_idx, 0);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int          bsz;
        int          bufsz;
        int          n;
        int          tmo;
        bit          cont;
        bit          waits;
        logic [31:0] sadr;
        int          e_beats;
        int          e_idx;
        int          e_done;
        int          e_bursts;
    } vec_t;

    vec_t vecs[11];

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt_before;
        bit reached;

        //          bsz buf  n tmo cont wait sadr           beats idx done bursts
        vecs[0]  = '{4,  16,  4, 0, 1'b1, 1'b0, 32'h0000_1000,  4,   4,  0,  1};
        vecs[1]  = '{4,  16, 10, 0, 1'b1, 1'b1, 32'h0000_2000,  8,   8,  0,  2};
        vecs[2]  = '{4,   6,  8, 0, 1'b0, 1'b0, 32'h0000_1000,  6,   0,  1,  2};
        vecs[3]  = '{4,   6, 10, 0, 1'b1, 1'b1, 32'h0000_1000, 10,   4,  1,  3};
        vecs[4]  = '{8,  16,  3,10, 1'b1, 1'b0, 32'h0000_1000,  3,   3,  0,  1};
        vecs[5]  = '{1,  16,  5, 0, 1'b1, 1'b0, 32'h0000_1000,  5,   5,  0,  5};
        vecs[6]  = '{1,   3,  5, 0, 1'b1, 1'b1, 32'h0000_1000,  5,   2,  1,  5};
        vecs[7]  = '{4,  16,  3, 0, 1'b1, 1'b0, 32'h0000_1000,  0,   0,  0,  0};
        vecs[8]  = '{16, 16, 16, 0, 1'b1, 1'b0, 32'h0000_1000, 16,   0,  1,  1};
        vecs[9]  = '{4,  16,  4, 0, 1'b1, 1'b0, 32'hFFFF_FFF8,  4,   4,  0,  1};
        vecs[10] = '{4,   5,  7, 3, 1'b1, 1'b0, 32'h0000_1000,  7,   2,  1,  3};

        // Reset state
        set_cfg(4, 16, 0, 1'b1, 32'h1000);
        do_reset();
        @(negedge clk);
        check_reset_outputs("reset");

        // Table-driven scenarios
        for (int i = 0; i < 11; i++) begin
            set_cfg(vecs[i].bsz, vecs[i].bufsz, vecs[i].tmo, vecs[i].cont, vecs[i].sadr);
            do_reset();
            wait_mode = vecs[i].waits;
            push_words(vecs[i].n);
            tick();
            enable = 1'b1;
            run_until_quiet($sformatf("v%0d", i));
            check($sformatf("v%0d beats", i), beats, vecs[i].e_beats);
            check($sformatf("v%0d idx", i), cur_idx, vecs[i].e_idx);
            check($sformatf("v%0d done", i), done_cnt, vecs[i].e_done);
            check($sformatf("v%0d bursts", i), bursts, vecs[i].e_bursts);
            check($sformatf("v%0d fifo_left", i), fifo_cnt, vecs[i].n - vecs[i].e_beats);
            $display("vector %0d: bsz=%0d buf=%0d n=%0d -> beats=%0d idx=%0d done=%0d bursts=%0d",
                     i, vecs[i].bsz, vecs[i].bufsz, vecs[i].n, beats, cur_idx, done_cnt, bursts);
        end

        // Timeout latency: counter reaches 10 in the 11th qualifying cycle,
        // bus rises in the 12th.
        set_cfg(8, 16, 10, 1'b1, 32'h1000);
        do_reset();
        push_words(3);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (wbm_cyc) break;
        end
        check("timeout_latency", n, 12);
        run_until_quiet("timeout");
        check("timeout beats", beats, 3);
        $display("timeout: cyc rose in cycle %0d, beats=%0d", n, beats);

        // Error on beat 2 of 4
        set_cfg(4, 16, 0, 1'b1, 32'h1000);
        do_reset();
        push_words(4);
        err_arm = 1; err_after = 1;
        tick();
        enable = 1'b1;
        run_until_quiet("err");
        check("err beats", beats, 1);
        check("err idx", cur_idx, 1);
        check("err err_o pulses", errp_cnt, 1);
        check("err fifo_cnt", fifo_cnt, 3);
        push_words(1);
        run_until_quiet("err_resume");
        check("err_resume beats", beats, 5);
        check("err_resume idx", cur_idx, 5);
        $display("error: beats=%0d idx=%0d err_pulses=%0d", beats, cur_idx, errp_cnt);

        // Retry on first beat: no err_o, burst retried in full
        do_reset();
        push_words(4);
        rty_arm = 1;
        tick();
        enable = 1'b1;
        run_until_quiet("rty");
        check("rty seen", rty_cnt, 1);
        check("rty beats", beats, 4);
        check("rty idx", cur_idx, 4);
        check("rty err_o pulses", errp_cnt, 0);
        check("rty bursts", bursts, 1);
        $display("retry: beats=%0d idx=%0d", beats, cur_idx);

        // One-shot: park after wrap until enable toggles
        set_cfg(4, 6, 0, 1'b0, 32'h1000);
        do_reset();
        push_words(12);
        tick();
        enable = 1'b1;
        run_until_quiet("hold");
        check("hold beats", beats, 6);
        check("hold idx", cur_idx, 0);
        check("hold done", done_cnt, 1);
        repeat (30) tick();
        check("hold parked beats", beats, 6);
        check("hold parked fifo", fifo_cnt, 6);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        run_until_quiet("hold_release");
        check("hold_release beats", beats, 10);
        check("hold_release idx", cur_idx, 4);
        check("hold_release fifo", fifo_cnt, 2);
        $display("hold: beats=%0d idx=%0d fifo=%0d", beats, cur_idx, fifo_cnt);

        // Reset in the middle of a long burst
        set_cfg(16, 16, 0, 1'b1, 32'h1000);
        do_reset();
        push_words(16);
        tick();
        enable = 1'b1;
        reached = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (beats >= 3) begin
                reached = 1;
                break;
            end
        end
        check("midrst reached beat 3", reached, 1);
        ack_hold = 1;
        tick();
        rst = 1'b1;
        cnt_before = int'(fifo_cnt);
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("midrst no pops", fifo_cnt, cnt_before);
        check("midrst idx", cur_idx, 0);
        check("midrst cyc", wbm_cyc, 0);
        $display("mid-burst reset: fifo=%0d idx=%0d", fifo_cnt, cur_idx);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
